// File: rtl/tl_beat_queue_pkg.sv
// Shared TileLink channel types, width constants and the beat-count helper
// used by tl_beat_queue and the arbiters built on it.
package tl_beat_queue_pkg;

   localparam int unsigned TL_ADDR_W   = 32;
   localparam int unsigned TL_SOURCE_W = 4;
   localparam int unsigned TL_SINK_W   = 4;
   localparam int unsigned TL_SIZE_W   = 4;
   localparam int unsigned TL_DATA_W   = 64;
   localparam int unsigned TL_MASK_W   = TL_DATA_W / 8;

   typedef struct packed {
      logic [2:0]             opcode;
      logic [2:0]             param;
      logic [TL_SIZE_W-1:0]   size;
      logic [TL_SOURCE_W-1:0] source;
      logic [TL_ADDR_W-1:0]   address;
      logic [TL_MASK_W-1:0]   mask;
      logic [TL_DATA_W-1:0]   data;
      logic                   corrupt;
   } tl_a_t;

   typedef struct packed {
      logic [2:0]             opcode;
      logic [1:0]             param;
      logic [TL_SIZE_W-1:0]   size;
      logic [TL_SOURCE_W-1:0] source;
      logic [TL_ADDR_W-1:0]   address;
      logic [TL_MASK_W-1:0]   mask;
      logic [TL_DATA_W-1:0]   data;
      logic                   corrupt;
   } tl_b_t;

   typedef struct packed {
      logic [2:0]             opcode;
      logic [2:0]             param;
      logic [TL_SIZE_W-1:0]   size;
      logic [TL_SOURCE_W-1:0] source;
      logic [TL_ADDR_W-1:0]   address;
      logic [TL_DATA_W-1:0]   data;
      logic                   corrupt;
   } tl_c_t;

   typedef struct packed {
      logic [2:0]             opcode;
      logic [1:0]             param;
      logic [TL_SIZE_W-1:0]   size;
      logic [TL_SOURCE_W-1:0] source;
      logic [TL_SINK_W-1:0]   sink;
      logic                   denied;
      logic [TL_DATA_W-1:0]   data;
      logic                   corrupt;
   } tl_d_t;

   typedef struct packed {
      logic [TL_SINK_W-1:0] sink;
   } tl_e_t;

   // Messages without data, or no larger than one bus beat, take one beat.
   function automatic int unsigned tl_num_beats(
      input int unsigned size,
      input logic        has_data,
      input int unsigned log2_beat_bytes
   );
      if (has_data && size > log2_beat_bytes)
         return 32'd1 << (size - log2_beat_bytes);
      return 32'd1;
   endfunction

endpackage

// File: rtl/tl_beat_queue_counter.sv
// tl_beat_counter: tracks beats left in the current message on a
// dequeue stream and flags first/last beats.
module tl_beat_counter
   import tl_beat_queue_pkg::*;
#(
   parameter int SIZE_W          = 4,
   parameter int LOG2_BEAT_BYTES = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [SIZE_W-1:0] size,
   input  logic              has_data,
   input  logic              fire,
   output logic              first,
   output logic              last
);

   // Wide enough to hold the beat count of the largest encodable message.
   localparam int RW = (1 << SIZE_W) - LOG2_BEAT_BYTES;

   logic [RW-1:0] remaining;
   logic [RW-1:0] beats;

   assign beats = RW'(tl_num_beats(32'(size), has_data, LOG2_BEAT_BYTES));
   assign first = (remaining == '0);
   assign last  = (remaining == RW'(1)) | (first & (beats == RW'(1)));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         remaining <= '0;
      else if (fire)
         remaining <= first ? beats - RW'(1) : remaining - RW'(1);
   end

endmodule

// File: rtl/tl_beat_queue.sv
// TileLink channel FIFO with dequeue-side first/last tracking.
// Define TL_QUEUE_BYPASS_EN to let an empty queue forward enq to deq combinationally.
module tl_beat_queue
   import tl_beat_queue_pkg::*;
#(
   parameter int PAYLOAD_W       = 64,
   parameter int DEPTH           = 4,
   parameter int SIZE_W          = 4,
   parameter int LOG2_BEAT_BYTES = 3,
   parameter int CNT_W           = $clog2(DEPTH + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enq_valid,
   output logic                 enq_ready,
   input  logic [PAYLOAD_W-1:0] enq_bits,
   input  logic [SIZE_W-1:0]    enq_size,
   input  logic                 enq_has_data,
   output logic                 deq_valid,
   input  logic                 deq_ready,
   output logic [PAYLOAD_W-1:0] deq_bits,
   output logic                 deq_first,
   output logic                 deq_last,
   output logic [CNT_W-1:0]     count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PAYLOAD_W-1:0] mem_bits [DEPTH];
   logic [SIZE_W-1:0]    mem_size [DEPTH];
   logic                 mem_data [DEPTH];

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              bypass;
   logic              enq_fire;
   logic              deq_fire;
   logic              push;
   logic              pop;
   logic [SIZE_W-1:0] head_size;
   logic              head_data;
   logic              cnt_last;

`ifdef TL_QUEUE_BYPASS_EN
   assign bypass = (count == '0) & enq_valid;
`else
   assign bypass = 1'b0;
`endif

   assign enq_ready = (count != CNT_W'(DEPTH));
   assign deq_valid = (count != '0) | bypass;
   assign enq_fire  = enq_valid & enq_ready;
   assign deq_fire  = deq_valid & deq_ready;

   // A bypassed beat consumed in the same cycle never touches storage.
   assign push = enq_fire & ~(bypass & deq_ready);
   assign pop  = deq_fire & ~bypass;

   assign deq_bits  = bypass ? enq_bits     : mem_bits[rd_ptr];
   assign head_size = bypass ? enq_size     : mem_size[rd_ptr];
   assign head_data = bypass ? enq_has_data : mem_data[rd_ptr];
   assign deq_last  = deq_valid & cnt_last;

   always_ff @(posedge clock) begin
      if (push) begin
         mem_bits[wr_ptr] <= enq_bits;
         mem_size[wr_ptr] <= enq_size;
         mem_data[wr_ptr] <= enq_has_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         if (push & ~pop)
            count <= count + 1'b1;
         else if (pop & ~push)
            count <= count - 1'b1;
      end
   end

   tl_beat_counter #(
      .SIZE_W          (SIZE_W),
      .LOG2_BEAT_BYTES (LOG2_BEAT_BYTES)
   ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .size     (head_size),
      .has_data (head_data),
      .fire     (deq_fire),
      .first    (deq_first),
      .last     (cnt_last)
   );

endmodule

// File: tb/tb_tl_beat_queue.sv
// Directed bench for tl_beat_queue (DEPTH 4, 64-bit payload, 8-byte beats).
// Bypass expectations follow TL_QUEUE_BYPASS_EN.
module tb_tl_beat_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic        enq_valid;
   logic        enq_ready;
   logic [63:0] enq_bits;
   logic [3:0]  enq_size;
   logic        enq_has_data;
   logic        deq_valid;
   logic        deq_ready;
   logic [63:0] deq_bits;
   logic        deq_first;
   logic        deq_last;
   logic [2:0]  count;

   int passed = 0;
   int total  = 0;

   tl_beat_queue #(
      .PAYLOAD_W       (64),
      .DEPTH           (4),
      .SIZE_W          (4),
      .LOG2_BEAT_BYTES (3)
   ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .enq_valid    (enq_valid),
      .enq_ready    (enq_ready),
      .enq_bits     (enq_bits),
      .enq_size     (enq_size),
      .enq_has_data (enq_has_data),
      .deq_valid    (deq_valid),
      .deq_ready    (deq_ready),
      .deq_bits     (deq_bits),
      .deq_first    (deq_first),
      .deq_last     (deq_last),
      .count        (count)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic enq_one(input logic [63:0] b, input logic [3:0] s,
                          input logic d);
      enq_valid    = 1'b1;
      enq_bits     = b;
      enq_size     = s;
      enq_has_data = d;
      tick();
      enq_valid = 1'b0;
   endtask

   task automatic deq_one();
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      enq_valid    = 1'b0;
      enq_bits     = '0;
      enq_size     = '0;
      enq_has_data = 1'b0;
      deq_ready    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (deq_valid !== 1'b0)
         $display("FAIL rst_deq_valid got %b want 0", deq_valid);
      else passed++;
      total++;
      if (count !== 3'd0)
         $display("FAIL rst_count got %0d want 0", count);
      else passed++;
      total++;
      if (enq_ready !== 1'b1)
         $display("FAIL rst_enq_ready got %b want 1", enq_ready);
      else passed++;
      total++;
      if (deq_first !== 1'b1)
         $display("FAIL rst_first got %b want 1", deq_first);
      else passed++;
      total++;
      if (deq_last !== 1'b0)
         $display("FAIL rst_last got %b want 0", deq_last);
      else passed++;
   endtask

   task automatic test_single();
      enq_one(64'h11, 4'd3, 1'b1);
      total++;
      if (deq_valid !== 1'b1 || count !== 3'd1)
         $display("FAIL single_valid got v=%b c=%0d want v=1 c=1",
                  deq_valid, count);
      else passed++;
      total++;
      if (deq_bits !== 64'h11 || deq_first !== 1'b1 || deq_last !== 1'b1)
         $display("FAIL single_head got %h f=%b l=%b want 11 f=1 l=1",
                  deq_bits, deq_first, deq_last);
      else passed++;
      deq_one();
      total++;
      if (count !== 3'd0 || deq_valid !== 1'b0)
         $display("FAIL single_drain got c=%0d v=%b want c=0 v=0",
                  count, deq_valid);
      else passed++;
   endtask

   task automatic test_burst();
      for (int i = 0; i < 8; i++) begin
         enq_one(64'(i) + 64'h40, 4'd6, 1'b1);
         total++;
         if (deq_bits !== 64'(i) + 64'h40 ||
             deq_first !== (i == 0) || deq_last !== (i == 7))
            $display("FAIL burst_beat%0d got %h f=%b l=%b want %h f=%b l=%b",
                     i, deq_bits, deq_first, deq_last, 64'(i) + 64'h40,
                     (i == 0), (i == 7));
         else passed++;
         deq_one();
         total++;
         if (u_dut.u_cnt.remaining !== 13'(7 - i))
            $display("FAIL burst_rem%0d got %0d want %0d",
                     i, u_dut.u_cnt.remaining, 7 - i);
         else passed++;
      end
   endtask

   task automatic test_nodata();
      enq_one(64'h77, 4'd6, 1'b0);
      total++;
      if (deq_first !== 1'b1 || deq_last !== 1'b1)
         $display("FAIL nodata_flags got f=%b l=%b want f=1 l=1",
                  deq_first, deq_last);
      else passed++;
      deq_one();
      total++;
      if (deq_first !== 1'b1 || count !== 3'd0)
         $display("FAIL nodata_after got f=%b c=%0d want f=1 c=0",
                  deq_first, count);
      else passed++;
   endtask

   task automatic test_full();
      deq_ready    = 1'b0;
      enq_size     = 4'd3;
      enq_has_data = 1'b1;
      enq_valid    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         enq_bits = 64'h100 + 64'(i);
         #1;
         total++;
         if (enq_ready !== (i < 4))
            $display("FAIL full_ready%0d got %b want %b",
                     i, enq_ready, (i < 4));
         else passed++;
         tick();
      end
      total++;
      if (count !== 3'd4)
         $display("FAIL full_count got %0d want 4", count);
      else passed++;
      enq_bits  = 64'h200;
      deq_ready = 1'b1;
      #1;
      total++;
      if (enq_ready !== 1'b0 || deq_bits !== 64'h100)
         $display("FAIL full_deq got r=%b %h want r=0 100",
                  enq_ready, deq_bits);
      else passed++;
      tick();
      enq_valid = 1'b0;
      total++;
      if (count !== 3'd3 || enq_ready !== 1'b1)
         $display("FAIL full_space got c=%0d r=%b want c=3 r=1",
                  count, enq_ready);
      else passed++;
      for (int i = 1; i < 4; i++) begin
         total++;
         if (deq_bits !== 64'h100 + 64'(i))
            $display("FAIL drain%0d got %h want %h",
                     i, deq_bits, 64'h100 + 64'(i));
         else passed++;
         tick();
      end
      deq_ready = 1'b0;
      total++;
      if (count !== 3'd0 || deq_valid !== 1'b0)
         $display("FAIL drain_empty got c=%0d v=%b want c=0 v=0",
                  count, deq_valid);
      else passed++;
   endtask

   task automatic test_back_to_back();
      enq_one(64'hA0, 4'd3, 1'b1);
      enq_valid = 1'b1;
      enq_bits  = 64'hB0;
      deq_ready = 1'b1;
      #1;
      total++;
      if (deq_bits !== 64'hA0)
         $display("FAIL b2b_head got %h want a0", deq_bits);
      else passed++;
      tick();
      enq_valid = 1'b0;
      #1;
      total++;
      if (count !== 3'd1 || deq_bits !== 64'hB0)
         $display("FAIL b2b_hold got c=%0d %h want c=1 b0", count, deq_bits);
      else passed++;
      tick();
      deq_ready = 1'b0;
      total++;
      if (count !== 3'd0)
         $display("FAIL b2b_drain got %0d want 0", count);
      else passed++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         enq_one(64'h300 + 64'(i), 4'd6, 1'b1);
         deq_one();
      end
      enq_one(64'h303, 4'd6, 1'b1);
      total++;
      if (deq_first !== 1'b0)
         $display("FAIL mid_first got %b want 0", deq_first);
      else passed++;
      reset = 1'b1;
      #1;
      total++;
      if (count !== 3'd0 || deq_valid !== 1'b0 || deq_first !== 1'b1)
         $display("FAIL mid_reset got c=%0d v=%b f=%b want c=0 v=0 f=1",
                  count, deq_valid, deq_first);
      else passed++;
      tick();
      reset = 1'b0;
      enq_one(64'h400, 4'd6, 1'b1);
      total++;
      if (deq_first !== 1'b1 || deq_last !== 1'b0 || deq_bits !== 64'h400)
         $display("FAIL post_reset got f=%b l=%b %h want f=1 l=0 400",
                  deq_first, deq_last, deq_bits);
      else passed++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_bypass();
      enq_valid    = 1'b1;
      enq_bits     = 64'hA5;
      enq_size     = 4'd3;
      enq_has_data = 1'b1;
      deq_ready    = 1'b1;
      #1;
`ifdef TL_QUEUE_BYPASS_EN
      total++;
      if (deq_valid !== 1'b1 || deq_bits !== 64'hA5 ||
          deq_first !== 1'b1 || deq_last !== 1'b1)
         $display("FAIL bypass_same got v=%b %h f=%b l=%b want v=1 a5 f=1 l=1",
                  deq_valid, deq_bits, deq_first, deq_last);
      else passed++;
      tick();
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      total++;
      if (count !== 3'd0)
         $display("FAIL bypass_count got %0d want 0", count);
      else passed++;
`else
      total++;
      if (deq_valid !== 1'b0)
         $display("FAIL nobypass_same got v=%b want 0", deq_valid);
      else passed++;
      tick();
      enq_valid = 1'b0;
      #1;
      total++;
      if (deq_valid !== 1'b1 || deq_bits !== 64'hA5 || count !== 3'd1)
         $display("FAIL nobypass_next got v=%b %h c=%0d want v=1 a5 c=1",
                  deq_valid, deq_bits, count);
      else passed++;
      tick();
      deq_ready = 1'b0;
      total++;
      if (count !== 3'd0)
         $display("FAIL nobypass_drain got %0d want 0", count);
      else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_nodata();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_bypass();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
